// File: rtl/tri_raster_ctrl.sv
// rtl/tri_raster_ctrl.sv - single-triangle bounding-box rasterizer sharing one edge cross-product unit
// Optional macro TRI_EARLY_REJECT_EN: leave the edge sequence as soon as one edge reports r > 0.
module tri_raster_ctrl #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic [CW-1:0] x2,
  input  logic [CW-1:0] y2,
  input  logic [CW-1:0] x3,
  input  logic [CW-1:0] y3,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          out_inside,
  output logic          out_last
);

  localparam int PW = 2 * (CW + 1);
  localparam int RW = PW + 1;

`ifdef TRI_EARLY_REJECT_EN
  localparam bit EarlyReject = 1'b1;
`else
  localparam bit EarlyReject = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_E1, S_E2, S_E3, S_EMIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  logic [CW-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CW-1:0] r_cx, r_cy;
  logic          r_neg_ok;

  logic [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [CW-1:0] w_xa, w_ya, w_xb, w_yb;
  logic signed [CW:0]   w_dxb, w_dyb, w_dxc, w_dyc;
  logic signed [PW-1:0] w_p1, w_p2;
  logic signed [RW-1:0] w_r;
  logic          w_r_le0, w_last, w_hs;

  assign w_xmin = (r_x1 < r_x2) ? ((r_x1 < r_x3) ? r_x1 : r_x3) : ((r_x2 < r_x3) ? r_x2 : r_x3);
  assign w_xmax = (r_x1 > r_x2) ? ((r_x1 > r_x3) ? r_x1 : r_x3) : ((r_x2 > r_x3) ? r_x2 : r_x3);
  assign w_ymin = (r_y1 < r_y2) ? ((r_y1 < r_y3) ? r_y1 : r_y3) : ((r_y2 < r_y3) ? r_y2 : r_y3);
  assign w_ymax = (r_y1 > r_y2) ? ((r_y1 > r_y3) ? r_y1 : r_y3) : ((r_y2 > r_y3) ? r_y2 : r_y3);

  // The edge unit's (a,b) vertex pair rotates with the edge state.
  always_comb begin
    w_xa = r_x1;
    w_ya = r_y1;
    w_xb = r_x2;
    w_yb = r_y2;
    case (r_state)
      S_E2: begin
        w_xa = r_x2; w_ya = r_y2; w_xb = r_x3; w_yb = r_y3;
      end
      S_E3: begin
        w_xa = r_x3; w_ya = r_y3; w_xb = r_x1; w_yb = r_y1;
      end
      default: ;
    endcase
  end

  assign w_dxb = $signed({1'b0, w_xb}) - $signed({1'b0, w_xa});
  assign w_dyb = $signed({1'b0, w_yb}) - $signed({1'b0, w_ya});
  assign w_dxc = $signed({1'b0, r_cx}) - $signed({1'b0, w_xa});
  assign w_dyc = $signed({1'b0, r_cy}) - $signed({1'b0, w_ya});
  assign w_p1  = PW'(w_dxb) * PW'(w_dyc);
  assign w_p2  = PW'(w_dyb) * PW'(w_dxc);
  assign w_r   = RW'(w_p1) - RW'(w_p2);

  assign w_r_le0 = w_r[RW-1] | ~|w_r;
  assign w_last  = (r_cx == r_xmax) && (r_cy == r_ymax);
  assign w_hs    = (r_state == S_EMIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_BBOX;
      S_BBOX: w_next = S_E1;
      S_E1:   w_next = (EarlyReject && !w_r_le0) ? S_EMIT : S_E2;
      S_E2:   w_next = (EarlyReject && !w_r_le0) ? S_EMIT : S_E3;
      S_E3:   w_next = S_EMIT;
      S_EMIT: if (out_ready) w_next = w_last ? S_DONE : S_E1;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0; r_x3 <= '0; r_y3 <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_neg_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x1 <= x1; r_y1 <= y1; r_x2 <= x2; r_y2 <= y2; r_x3 <= x3; r_y3 <= y3;
        end
        S_BBOX: begin
          r_xmin <= w_xmin; r_xmax <= w_xmax;
          r_ymin <= w_ymin; r_ymax <= w_ymax;
          r_cx   <= w_xmin;
          r_cy   <= w_ymin;
        end
        S_E1:        r_neg_ok <= w_r_le0;
        S_E2, S_E3:  r_neg_ok <= r_neg_ok & w_r_le0;
        S_EMIT: if (w_hs && !w_last) begin
          if (r_cx == r_xmax) begin
            r_cx <= r_xmin;
            r_cy <= r_cy + CW'(1);
          end else begin
            r_cx <= r_cx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel registers hold still through EMIT, so a stalled pixel stays stable.
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign out_valid  = (r_state == S_EMIT);
  assign out_x      = r_cx;
  assign out_y      = r_cy;
  assign out_inside = (r_state == S_EMIT) && r_neg_ok;
  assign out_last   = (r_state == S_EMIT) && w_last;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// tb/tb_tri_raster_ctrl.sv - randomized bench for tri_raster_ctrl against a pixel-list reference model
module tb_tri_raster_ctrl;
  localparam int CW = 11;

`ifdef TRI_EARLY_REJECT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [CW-1:0] x1, y1, x2, y2, x3, y3;
  logic          busy, done, out_valid, out_inside, out_last;
  logic [CW-1:0] out_x, out_y;

  tri_raster_ctrl #(.CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_inside(out_inside), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected pixel stream: coordinates, flags and cycles from the previous reference point.
  int q_x[$], q_y[$], q_in[$], q_last[$], q_gap[$];
  int model_inside;

  function automatic longint edge_r(input longint ax, ay, bx, by, cx, cy);
    return (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
  endfunction

  task automatic build_model(input int ax, ay, bx, by, cx, cy);
    int vx[3];
    int vy[3];
    int xmin, xmax, ymin, ymax;
    vx[0] = ax; vx[1] = bx; vx[2] = cx;
    vy[0] = ay; vy[1] = by; vy[2] = cy;
    xmin = vx[0]; xmax = vx[0]; ymin = vy[0]; ymax = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xmin) xmin = vx[i];
      if (vx[i] > xmax) xmax = vx[i];
      if (vy[i] < ymin) ymin = vy[i];
      if (vy[i] > ymax) ymax = vy[i];
    end
    q_x.delete(); q_y.delete(); q_in.delete(); q_last.delete(); q_gap.delete();
    model_inside = 0;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        int ff;
        ff = 0;
        for (int e = 0; e < 3; e++)
          if (ff == 0 && edge_r(vx[e], vy[e], vx[(e+1)%3], vy[(e+1)%3], x, y) > 0) ff = e + 1;
        q_x.push_back(x);
        q_y.push_back(y);
        q_in.push_back(ff == 0 ? 1 : 0);
        q_last.push_back((x == xmax && y == ymax) ? 1 : 0);
        q_gap.push_back(1 + ((EARLY && ff != 0) ? ff : 3));
        if (ff == 0) model_inside++;
      end
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: hold pixel (1,0) for 7 cycles.
  task automatic run_tri(input int ax, ay, bx, by, cx, cy, input int mode,
                         input int exp_inside, input bit poke, input bit start_in_done);
    int k, ref_k, idx, stall, n_in;
    bit seen, got_last, rdy;
    build_model(ax, ay, bx, by, cx, cy);
    @(posedge clk); #1;
    x1 = ax[CW-1:0]; y1 = ay[CW-1:0]; x2 = bx[CW-1:0];
    y2 = by[CW-1:0]; x3 = cx[CW-1:0]; y3 = cy[CW-1:0];
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; ref_k = 1; idx = 0; stall = 0; n_in = 0; seen = 0; got_last = 0;
    check("busy_after_start", longint'(busy), 1);
    check("valid_in_bbox", longint'(out_valid), 0);
    while (!got_last && k < 4000) begin
      if (poke && k == 3) begin
        start = 1'b1;
        x1 = CW'($urandom); y1 = CW'($urandom); x2 = CW'($urandom);
        y2 = CW'($urandom); x3 = CW'($urandom); y3 = CW'($urandom);
      end else begin
        start = 1'b0;
      end
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (idx >= q_x.size()) begin
          check("extra_pixel", idx, q_x.size() - 1);
          break;
        end
        if (!seen) begin
          check("pixel_gap", k - ref_k, q_gap[idx]);
          seen = 1;
        end
        check("out_x", longint'(out_x), q_x[idx]);
        check("out_y", longint'(out_y), q_y[idx]);
        check("out_inside", longint'(out_inside), q_in[idx]);
        check("out_last", longint'(out_last), q_last[idx]);
        if (mode == 2) begin
          rdy = 1'b1;
          if (q_x[idx] == 1 && q_y[idx] == 0 && stall < 7) begin
            rdy = 1'b0;
            stall++;
          end
        end
        if (rdy) begin
          if (out_inside) n_in++;
          if (q_last[idx] != 0) got_last = 1;
          ref_k = k;
          seen = 0;
          idx++;
        end
      end
      out_ready = rdy;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (!got_last) begin
      check("scan_timeout", 0, 1);
    end else begin
      check("done_pulse", longint'(done), 1);
      check("busy_in_done", longint'(busy), 1);
      check("valid_in_done", longint'(out_valid), 0);
      if (start_in_done) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_cleared", longint'(done), 0);
      check("busy_idle", longint'(busy), 0);
      @(posedge clk); #1;
      check("busy_still_idle", longint'(busy), 0);
    end
    check("pixel_count", idx, q_x.size());
    if (mode == 2) check("stall_cycles", stall, 7);
    check("inside_count", n_in, (exp_inside < 0) ? model_inside : exp_inside);
  endtask

  initial begin
    int bx0, by0;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_x", longint'(out_x), 0);
    check("rst_y", longint'(out_y), 0);
    check("rst_inside", longint'(out_inside), 0);
    check("rst_last", longint'(out_last), 0);
    rst_n = 1'b1;

    run_tri(0, 0, 0, 4, 4, 0, 0, 15, 1'b0, 1'b0);
    run_tri(0, 0, 0, 4, 4, 0, 2, 15, 1'b0, 1'b0);
    run_tri(9, 9, 9, 9, 9, 9, 0, 1, 1'b0, 1'b1);
    run_tri(0, 0, 4, 0, 0, 4, 1, 0, 1'b1, 1'b0);

    @(posedge clk); #1;
    x1 = 0; y1 = 0; x2 = 0; y2 = 6; x3 = 6; y3 = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_valid", longint'(out_valid), 0);
    check("abort_x", longint'(out_x), 0);
    check("abort_y", longint'(out_y), 0);
    check("abort_inside", longint'(out_inside), 0);
    check("abort_last", longint'(out_last), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_done", longint'(done), 0);
    end

    run_tri(0, 0, 0, 4, 4, 0, 1, 15, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      bx0 = (t == 7) ? 2040 : $urandom_range(0, 2040);
      by0 = (t == 7) ? 2040 : $urandom_range(0, 2040);
      run_tri(bx0 + $urandom_range(0, 7), by0 + $urandom_range(0, 7),
              bx0 + $urandom_range(0, 7), by0 + $urandom_range(0, 7),
              bx0 + $urandom_range(0, 7), by0 + $urandom_range(0, 7),
              (t % 2 == 0) ? 1 : 0, -1, 1'(t == 3), 1'(t == 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_raster_ctrl.md
# tri_raster_ctrl

Sequencer that rasterizes one triangle over its bounding box using a single time-shared edge cross-product unit. It evaluates three edge functions per pixel, one per cycle, and streams each pixel out with an inside/outside flag over a valid/ready interface. It sits between the vertex setup stage and the pixel write stage. It replaces three parallel cross-product instances with one shared unit plus this controller.

## Interface
Parameters:
- `CW`, 11: coordinate width, unsigned.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a triangle; sampled only in IDLE.
- `x1`,`y1`,`x2`,`y2`,`x3`,`y3`  in  CW each  vertex coordinates; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `out_valid`  out  1  pixel available.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_x`,`out_y`  out  CW  pixel coordinates.
- `out_inside`  out  1  pixel inside or on the triangle.
- `out_last`  out  1  qualifies the final pixel of the bounding box.

## Operation
- Shared edge unit: r = (xb−xa)·(cy−ya) − (yb−ya)·(cx−xa).
  - Operands are zero-extended to CW+1 signed before subtraction.
  - Products are 2(CW+1) bits; r is 2(CW+1)+1 = 25 bits signed for CW=11, so there is no overflow.
- Edge sequence per pixel:
  - E1 uses (a,b) = (v1,v2).
  - E2 uses (v2,v3).
  - E3 uses (v3,v1).
- A pixel is inside iff all three r ≤ 0. Sticky flag `neg_ok` resets to 1 at E1 and is ANDed with (r ≤ 0) each edge cycle.
- Bounding box: xmin/xmax/ymin/ymax are computed from the latched vertices. Scan is raster order: cx increments xmin→xmax; at xmax, cx wraps to xmin and cy increments; the scan ends at (xmax,ymax).
- FSM states:
  - IDLE: on `start`, latch vertices → BBOX. `start` is ignored in all other states.
  - BBOX: register min/max, set cx=xmin, cy=ymin → E1.
  - E1 → E2 → E3 → EMIT.
  - EMIT: hold `out_valid` and all out_* stable until `out_ready`. On handshake, if the pixel is last → DONE; else advance the pixel → E1.
  - DONE: `done`=1 for one cycle → IDLE.
- Degenerate triangles (collinear or coincident vertices) are not special-cased. All-coincident vertices give one pixel with inside=1.
- Reset values: state IDLE, `busy`=0, `done`=0, `out_valid`=0, `out_x`=`out_y`=0, `out_inside`=0, `out_last`=0.
- Asserting `rst_n` low mid-scan aborts immediately to IDLE. No `done` is produced for the aborted triangle.

## Timing
- `start` accepted at cycle t → BBOX at t+1 (`busy`=1), E1 at t+2, first `out_valid` at t+5.
- Unstalled throughput is 4 cycles per pixel: E1, E2, E3, and EMIT with `out_ready`=1.
- With `out_ready` low, EMIT holds indefinitely. Outputs must not change while `out_valid`=1 and `out_ready`=0.
- The last handshake at cycle n gives `done`=1 and `busy`=1 at n+1, then `busy`=0 at n+2 (IDLE).
- A `start` asserted during the `done` cycle is ignored. It is accepted from the IDLE cycle onward.
- `out_valid` is low in every state except EMIT.

## Configuration
- `TRI_EARLY_REJECT_EN` defined: an edge cycle with r > 0 jumps directly to EMIT with `out_inside`=0, skipping the remaining edges.
  - An outside pixel then costs 2–4 cycles.
  - Pixel order and flags are identical to the undefined case.
- `TRI_EARLY_REJECT_EN` undefined: all three edges are always evaluated, at a fixed 4 cycles per pixel.

## Test plan
- Vertices (0,0),(0,4),(4,0) with `out_ready`=1 → 25 pixels in raster order, exactly 15 with `out_inside`=1 (cx+cy≤4). (2,2)=1 (edge r=0), (3,2)=0. `out_last` only on (4,4). `done` one cycle later.
- Same triangle, macro undefined → first `out_valid` at t+5, consecutive pixels 4 cycles apart. Macro defined → pixel (4,4) emitted 2 cycles after its E1.
- Backpressure: `out_ready` low for 7 cycles on pixel (1,0) → `out_valid`, `out_x`=1, `out_y`=0, `out_inside` held stable. The scan resumes after the handshake with no pixel lost or duplicated.
- Degenerate: all vertices (9,9) → single pixel (9,9), inside=1, `out_last`=1.
- `start` pulsed while `busy` → ignored, and the latched vertices are unchanged. `rst_n` low mid-scan → all outputs reach reset values asynchronously. A later `start` rasterizes correctly from IDLE.
- Vertices (0,0),(4,0),(0,4) (opposite winding) → all 25 pixels `out_inside`=0, except pixels where all three r are 0 (none here).
